// File: rtl/mmcm_clkgen_model.sv
// Behavioural MMCM stand-in: CLK_OUT averages f(CLKIN1)*M/(D*O), LOCKED after LOCK_CYCLES edges.
// Optional macro MMCM_CLKGEN_GATE_EN holds CLK_OUT low until LOCKED is high.
`timescale 1ns/1ps
module mmcm_clkgen_model #(
   parameter int DIVCLK_DIVIDE  = 1,
   parameter int CLKFBOUT_MULT  = 10,
   parameter int CLKOUT0_DIVIDE = 10,
   parameter int LOCK_CYCLES    = 64
) (
   input  logic CLKIN1,
   input  logic ASYNC_RESET,
   output logic CLK_OUT,
   output logic LOCKED
);
   localparam int DO_PROD = DIVCLK_DIVIDE * CLKOUT0_DIVIDE;
   localparam int M_X2    = 2 * CLKFBOUT_MULT;
   localparam bit BYPASS  = (CLKFBOUT_MULT == DO_PROD);
   localparam bit DIVIDE  = !BYPASS && (M_X2 <= DO_PROD);
   // M=1 is accepted so that pure integer dividers (M=1, D*O even) can be modelled.
   localparam bit PARAM_OK = (DIVCLK_DIVIDE >= 1) && (DIVCLK_DIVIDE <= 106) &&
                             (CLKFBOUT_MULT >= 1) && (CLKFBOUT_MULT <= 64) &&
                             (CLKOUT0_DIVIDE >= 1) && (CLKOUT0_DIVIDE <= 128) &&
                             (LOCK_CYCLES >= 1) && (LOCK_CYCLES <= 1023);
   localparam int ACC_W = $clog2(DO_PROD) + 1;
   localparam logic [10:0] LOCK_TARGET = 11'(LOCK_CYCLES);

   logic [9:0]  lock_cnt_q, lock_cnt_d;
   logic [10:0] lock_cnt_inc;
   logic        locked_q, locked_d;
   logic        run_en;

`ifdef MMCM_CLKGEN_GATE_EN
   assign run_en = locked_q;
`else
   assign run_en = 1'b1;
`endif

   always_comb begin
      lock_cnt_inc = {1'b0, lock_cnt_q} + 11'd1;
      lock_cnt_d   = lock_cnt_q;
      locked_d     = locked_q;
      if (!locked_q) begin
         lock_cnt_d = lock_cnt_inc[9:0];
         if (lock_cnt_inc == LOCK_TARGET) begin
            locked_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLKIN1 or posedge ASYNC_RESET) begin
      if (ASYNC_RESET) begin
         lock_cnt_q <= 10'd0;
         locked_q   <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign LOCKED = locked_q;

   if (!PARAM_OK) begin : g_bad_param
      $fatal(1, "mmcm_clkgen_model: parameter out of range (D=%0d M=%0d O=%0d LOCK=%0d)",
             DIVCLK_DIVIDE, CLKFBOUT_MULT, CLKOUT0_DIVIDE, LOCK_CYCLES);
   end

   if (BYPASS) begin : g_bypass
      logic gate_en_q, gate_en_d;

      always_comb begin
         gate_en_d = run_en;
      end

      // Sampled while CLKIN1 is low so the AND gate can never cut a high phase short.
      always_ff @(negedge CLKIN1 or posedge ASYNC_RESET) begin
         if (ASYNC_RESET) begin
            gate_en_q <= 1'b0;
         end else begin
            gate_en_q <= gate_en_d;
         end
      end

      assign CLK_OUT = CLKIN1 & gate_en_q;
   end else if (DIVIDE) begin : g_divide
      logic [ACC_W-1:0] acc_q, acc_d;
      logic [ACC_W:0]   acc_sum;
      logic             tgl_q, tgl_d;

      // Fractional divider: add 2*M per input edge, toggle each time D*O is crossed.
      always_comb begin
         acc_sum = {1'b0, acc_q} + (ACC_W+1)'(M_X2);
         acc_d   = acc_q;
         tgl_d   = tgl_q;
         if (run_en) begin
            if (acc_sum >= (ACC_W+1)'(DO_PROD)) begin
               acc_d = ACC_W'(acc_sum - (ACC_W+1)'(DO_PROD));
               tgl_d = ~tgl_q;
            end else begin
               acc_d = acc_sum[ACC_W-1:0];
            end
         end
      end

      always_ff @(posedge CLKIN1 or posedge ASYNC_RESET) begin
         if (ASYNC_RESET) begin
            acc_q <= '0;
            tgl_q <= 1'b0;
         end else begin
            acc_q <= acc_d;
            tgl_q <= tgl_d;
         end
      end

      assign CLK_OUT = tgl_q;
   end else begin : g_bad_ratio
      $fatal(1, "mmcm_clkgen_model: unsupported ratio M=%0d D*O=%0d (need M==D*O or 2*M<=D*O)",
             CLKFBOUT_MULT, DO_PROD);
      assign CLK_OUT = 1'b0;
   end

endmodule

// File: tb/tb_mmcm_clkgen_model.sv
// Self-checking bench for mmcm_clkgen_model: one bypass and three divide instances on a shared
// clock/reset, compared against an edge-count arithmetic reference model.
`timescale 1ns/1ps
module tb_mmcm_clkgen_model;

`ifdef MMCM_CLKGEN_GATE_EN
   localparam bit GATED = 1'b1;
`else
   localparam bit GATED = 1'b0;
`endif

   logic clk, rst;
   logic byp_out, byp_lock;
   logic d4_out, d4_lock;
   logic d5_out, d5_lock;
   logic d14_out, d14_lock;

   int  n_checks = 0;
   int  n_errors = 0;
   int  n_rise   = 0;
   bit  gate_m   = 1'b0;
   int  tgl_cnt  = 0;
   int  tgl_base = 0;
   time last_t[4];
   bit  have_last[4];
   time min_w    = 1000;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   mmcm_clkgen_model u_byp (
      .CLKIN1(clk), .ASYNC_RESET(rst), .CLK_OUT(byp_out), .LOCKED(byp_lock));

   mmcm_clkgen_model #(.DIVCLK_DIVIDE(1), .CLKFBOUT_MULT(1), .CLKOUT0_DIVIDE(4), .LOCK_CYCLES(5)) u_d4 (
      .CLKIN1(clk), .ASYNC_RESET(rst), .CLK_OUT(d4_out), .LOCKED(d4_lock));

   mmcm_clkgen_model #(.DIVCLK_DIVIDE(1), .CLKFBOUT_MULT(2), .CLKOUT0_DIVIDE(5), .LOCK_CYCLES(17)) u_d5 (
      .CLKIN1(clk), .ASYNC_RESET(rst), .CLK_OUT(d5_out), .LOCKED(d5_lock));

   mmcm_clkgen_model #(.DIVCLK_DIVIDE(2), .CLKFBOUT_MULT(3), .CLKOUT0_DIVIDE(7), .LOCK_CYCLES(1)) u_d14 (
      .CLKIN1(clk), .ASYNC_RESET(rst), .CLK_OUT(d14_out), .LOCKED(d14_lock));

   // ---------------- reference model ----------------
   always @(posedge clk) if (!rst) n_rise++;
   always @(negedge clk) if (!rst) gate_m = GATED ? (n_rise >= 64) : 1'b1;

   // Output toggles after n input edges = floor(2*M*n_eff / (D*O)).
   function automatic logic div_ref(input int m, input int dprod, input int lock, input int n);
      int ne;
      ne = n;
      if (GATED) ne = (n > lock) ? (n - lock) : 0;
      return logic'(((2 * m * ne) / dprod) % 2);
   endfunction

   always @(d5_out) if (!rst) tgl_cnt++;

   task automatic note_edge(input int k);
      if (rst) begin
         have_last[k] = 1'b0;
      end else begin
         if (have_last[k] && (($time - last_t[k]) < min_w)) min_w = $time - last_t[k];
         last_t[k]    = $time;
         have_last[k] = 1'b1;
      end
   endtask

   always @(byp_out) note_edge(0);
   always @(d4_out)  note_edge(1);
   always @(d5_out)  note_edge(2);
   always @(d14_out) note_edge(3);

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check_val("byp_locked", 32'(byp_lock), 32'(n_rise >= 64));
      check_val("byp_clk",    32'(byp_out),  32'(clk & gate_m));
      check_val("d4_locked",  32'(d4_lock),  32'(n_rise >= 5));
      check_val("d4_clk",     32'(d4_out),   32'(div_ref(1, 4, 5, n_rise)));
      check_val("d5_locked",  32'(d5_lock),  32'(n_rise >= 17));
      check_val("d5_clk",     32'(d5_out),   32'(div_ref(2, 5, 17, n_rise)));
      check_val("d14_locked", 32'(d14_lock), 32'(n_rise >= 1));
      check_val("d14_clk",    32'(d14_out),  32'(div_ref(3, 14, 1, n_rise)));
   endtask

   task automatic check_reset_state(input string phase);
      check_val({phase, "_byp_lock"}, 32'(byp_lock), 32'd0);
      check_val({phase, "_byp_clk"},  32'(byp_out),  32'd0);
      check_val({phase, "_d4_lock"},  32'(d4_lock),  32'd0);
      check_val({phase, "_d4_clk"},   32'(d4_out),   32'd0);
      check_val({phase, "_d5_lock"},  32'(d5_lock),  32'd0);
      check_val({phase, "_d5_clk"},   32'(d5_out),   32'd0);
      check_val({phase, "_d14_lock"}, 32'(d14_lock), 32'd0);
      check_val({phase, "_d14_clk"},  32'(d14_out),  32'd0);
   endtask

   // ---------------- driver ----------------
   task automatic pulse_reset(input bit in_high);
      if (in_high) @(posedge clk); else @(negedge clk);
      #1 rst = 1'b1;
      n_rise = 0;
      gate_m = 1'b0;
      #1 check_reset_state(in_high ? "rst_hi" : "rst_lo");
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      #1 check_reset_state("por");
      #101 rst = 1'b0;
      for (int ep = 0; ep < 6; ep++) begin
         int cycles;
         cycles = $urandom_range(90, 140);
         for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #2 check_all();
            if (ep == 0 && n_rise == 20) tgl_base = tgl_cnt;
            if (ep == 0 && n_rise == 70) check_val("d5_toggles_50_edges", 32'(tgl_cnt - tgl_base), 32'd40);
            @(negedge clk);
            #2 check_all();
         end
         pulse_reset(ep == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      check_val("min_pulse_ge_5ns", 32'(min_w >= 5), 32'd1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
